// File: rtl/smoke_clkgen.sv
// smoke_clkgen: programmable-duty clock generator driven from a free-running
// base clock. Counts generated rising edges and offers a request/acknowledge
// "wait N generated edges" service for a BFM that must block on DUT cycles.
module smoke_clkgen #(
  parameter int CNT_W  = 16,
  parameter int EDGE_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  input  logic              run,
  output logic              clk_out,
  output logic              posedge_pulse,
  output logic [EDGE_W-1:0] edge_count,
  input  logic              wait_valid,
  input  logic [EDGE_W-1:0] wait_cycles,
  output logic              wait_ready,
  output logic              wait_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  PH_ONE   = CNT_W'(1);
  localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_ph;
  logic [CNT_W-1:0]   w_ph_next;
  logic [CNT_W-1:0]   r_high;
  logic [CNT_W-1:0]   r_low;
  logic [CNT_W-1:0]   w_high_next;
  logic [CNT_W-1:0]   w_low_next;
  logic               r_clk_out;
  logic               r_pulse;
  logic [EDGE_W-1:0]  r_edge_count;
  logic [EDGE_W-1:0]  r_rem;
  logic               r_wait_ready;
  logic               r_wait_done;
  logic               w_wait_accept;

  // Configuration is only taken while the generator is parked.
  assign cfg_ready     = (r_state == ST_IDLE);
  assign clk_out       = r_clk_out;
  assign posedge_pulse = r_pulse;
  assign edge_count    = r_edge_count;
  assign wait_ready    = r_wait_ready;
  assign wait_done     = r_wait_done;
  assign w_wait_accept = wait_valid && r_wait_ready;

  // Next-state logic: phase sequencing and config capture (zero clamps to 1).
  always_comb begin
    w_state_next = r_state;
    w_ph_next    = r_ph;
    w_high_next  = r_high;
    w_low_next   = r_low;
    case (r_state)
      ST_IDLE: begin
        if (cfg_valid) begin
          w_high_next = (cfg_high == '0) ? PH_ONE : cfg_high;
          w_low_next  = (cfg_low  == '0) ? PH_ONE : cfg_low;
        end
        if (run) begin
          w_state_next = ST_HIGH;
          w_ph_next    = PH_ONE;
        end
      end
      ST_HIGH: begin
        if (r_ph == r_high) begin
          w_state_next = ST_LOW;
          w_ph_next    = PH_ONE;
        end else begin
          w_ph_next = r_ph + PH_ONE;
        end
      end
      ST_LOW: begin
        // run is only looked at on the last low cycle, so a stop never
        // truncates a period.
        if (r_ph == r_low) begin
          w_state_next = run ? ST_HIGH : ST_IDLE;
          w_ph_next    = PH_ONE;
        end else begin
          w_ph_next = r_ph + PH_ONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_ph_next    = PH_ONE;
      end
    endcase
  end

  // State, phase counter, config and registered clock/pulse outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ph      <= PH_ONE;
      r_high    <= PH_ONE;
      r_low     <= PH_ONE;
      r_clk_out <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ph      <= w_ph_next;
      r_high    <= w_high_next;
      r_low     <= w_low_next;
      r_clk_out <= (w_state_next == ST_HIGH);
      r_pulse   <= (w_state_next == ST_HIGH) && (r_state != ST_HIGH);
    end
  end

  // Rising-edge counter; free-running wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_edge_count <= '0;
    end else if (r_pulse) begin
      r_edge_count <= r_edge_count + EDGE_ONE;
    end
  end

  // Wait service: an accept takes priority over a coincident edge pulse,
  // so the pulse in the accept cycle is never counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem        <= '0;
      r_wait_ready <= 1'b1;
      r_wait_done  <= 1'b0;
    end else begin
      r_wait_done <= 1'b0;
      if (w_wait_accept) begin
        r_rem <= wait_cycles;
        if (wait_cycles == '0) begin
          r_wait_done  <= 1'b1;
          r_wait_ready <= 1'b1;
        end else begin
          r_wait_ready <= 1'b0;
        end
      end else if (!r_wait_ready && r_pulse) begin
        r_rem <= r_rem - EDGE_ONE;
        if (r_rem == EDGE_ONE) begin
          r_wait_done  <= 1'b1;
          r_wait_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/smoke_clkgen.md
Name: smoke_clkgen

Overview:
- Producer side of the testbench clock interface: generates the `clock` that smoke-style DUT modules consume.
- The clock is a programmable-duty-cycle signal derived from a free-running base clock.
- Counts generated rising edges.
- Provides a request/acknowledge "wait N edges" service so a tblink-rpc BFM can block on simulated clock cycles without time-unit delays.
- Sits between the base clock source and the DUT clock input.

Parameters:
CNT_W, 16, width of high/low phase length fields (base-clock cycles)
EDGE_W, 32, width of the edge counter and wait-cycle request

Ports:
clock  input  1  base clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
cfg_valid  input  1  new phase-length configuration offered
cfg_ready  output  1  configuration accepted this cycle when cfg_valid && cfg_ready
cfg_high  input  CNT_W  base cycles clk_out is high per period
cfg_low  input  CNT_W  base cycles clk_out is low per period
run  input  1  level enable for clock generation
clk_out  output  1  generated clock (registered)
posedge_pulse  output  1  one base cycle, coincident with clk_out rising
edge_count  output  EDGE_W  generated rising edges since reset
wait_valid  input  1  wait request offered
wait_cycles  input  EDGE_W  number of generated rising edges to wait
wait_ready  output  1  wait request accepted when wait_valid && wait_ready
wait_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async assert, sync-released use):
  - clk_out=0, posedge_pulse=0, edge_count=0, wait_done=0.
  - cfg_ready=1, wait_ready=1.
  - high_r=1, low_r=1; state IDLE; any pending wait is dropped with no wait_done.
- Config:
  - cfg_ready=1 only in IDLE.
  - On accept, high_r<=max(cfg_high,1) and low_r<=max(cfg_low,1); a zero value clamps to 1.
- FSM states: IDLE, HIGH, LOW; phase counter ph (CNT_W).
  - IDLE: if run=1 -> HIGH next cycle, ph<=1.
  - HIGH: if ph==high_r -> LOW with ph<=1, else ph++.
  - LOW: if ph==low_r -> HIGH (if run=1) or IDLE (if run=0) with ph<=1, else ph++.
  - clk_out = (state==HIGH), registered; high for exactly high_r cycles, low for low_r; period = high_r+low_r.
  - Deasserting run mid-period completes the current high and low phases, then enters IDLE. No truncated pulses.
  - Config is not accepted while running.
- posedge_pulse:
  - 1 in the first cycle of every HIGH phase.
  - edge_count increments in that same cycle (visible the next cycle) and wraps modulo 2^EDGE_W.
- Wait service:
  - On accept, wait_ready<=0 and rem<=wait_cycles.
  - A posedge_pulse in the acceptance cycle is not counted.
  - Each later posedge_pulse decrements rem. When rem reaches 0 via a posedge_pulse, wait_done=1 on the following cycle and wait_ready=1 in that same cycle.
  - A new request may be accepted in the wait_done cycle.
  - wait_cycles=0: wait_done the cycle after acceptance.
  - While IDLE with a pending wait, rem holds; the wait completes once run resumes edge generation.
- Simultaneous cfg accept and run=1 in IDLE: the new config applies to the period that starts next cycle.
- Reset mid-period or mid-wait: immediate return to reset values; clk_out drops to 0 asynchronously.

Test Plan:
- Reset, cfg high=2 low=3, then run=1 held -> clk_out pattern 1,1,0,0,0 repeating from the cycle after run; posedge_pulse every 5 cycles; edge_count=4 after the 4th pulse.
- cfg high=0 low=0, run=1 -> clamped to 1/1; clk_out toggles every base cycle; cfg_ready=0 while running.
- run=1, then run=0 in the 1st HIGH cycle (high=3, low=2) -> full 3 high + 2 low cycles complete, then IDLE with clk_out=0, cfg_ready=1.
- high=1 low=1, wait_cycles=3 accepted -> wait_done exactly one cycle after the 3rd posedge_pulse after acceptance; wait_ready low throughout; wait_cycles=0 -> wait_done next cycle.
- Set EDGE_W=4 and generate 17 edges -> edge_count wraps to 1.
- Assert reset while a wait_cycles=5 request is pending, mid-HIGH phase -> clk_out=0 immediately; no wait_done; wait_ready=1 and edge_count=0 after release.
